// File: rtl/tt_lpf_scan_ctrl_if.sv
// Register-side request/response bundle for the loop-filter scan sequencer.
// The master is the config/debug register block; the slave is the sequencer.
interface tt_lpf_scan_ctrl_if #(
    parameter int CHAIN_LEN = 32
);
    logic                 i_req;
    logic                 i_op;
    logic [CHAIN_LEN-1:0] i_wdata;
    logic                 o_ready;
    logic                 o_done;
    logic [CHAIN_LEN-1:0] o_rdata;

    modport master (
        output i_req,
        output i_op,
        output i_wdata,
        input  o_ready,
        input  o_done,
        input  o_rdata
    );

    modport slave (
        input  i_req,
        input  i_op,
        input  i_wdata,
        output o_ready,
        output o_done,
        output o_rdata
    );
endinterface

// File: rtl/tt_lpf_scan_ctrl.sv
// Scan-chain sequencer for the PLL loop-filter integrator.
// One request drives scan enable for exactly CHAIN_LEN cycles, either loading a
// new accumulator value (write) or recirculating the old one (read); the bits
// leaving the chain are always captured so the prior value can be read back.
module tt_lpf_scan_ctrl #(
    parameter int CHAIN_LEN = 32
) (
    input  logic                  i_clk_gen,
    input  logic                  i_rst_n,
    tt_lpf_scan_ctrl_if.slave     bus,
    output logic                  o_scan_en,
    output logic                  o_scan_in,
    input  logic                  i_scan_out
);

    localparam int CNT_W = $clog2(CHAIN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rx_q, rx_d;
    logic                 op_q, op_d;
    logic                 scan_en_q, scan_en_d;

    // State register and datapath flops; reset discards any partial operation.
    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            op_q      <= 1'b0;
            scan_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            op_q      <= op_d;
            scan_en_q <= scan_en_d;
        end
    end

    // Next-state logic: latch the request, shift CHAIN_LEN times, pulse done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(CHAIN_LEN - 1);
                    tx_d    = bus.i_wdata;
                    op_d    = bus.i_op;
                end
            end
            ST_SHIFT: begin
                tx_d = {tx_q[CHAIN_LEN-2:0], 1'b0};
                rx_d = {rx_q[CHAIN_LEN-2:0], i_scan_out};
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        scan_en_d = (state_d == ST_SHIFT);
    end

    assign o_scan_en   = scan_en_q;
    assign o_scan_in   = scan_en_q ? (op_q ? tx_q[CHAIN_LEN-1] : i_scan_out) : 1'b0;
    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_done  = (state_q == ST_DONE);
    assign bus.o_rdata = rx_q;

endmodule
